// File: rtl/input_debounce_pkg.sv
// Shared timing constants and sizing helpers for the input debounce block.
package input_debounce_pkg;

  // Board clock and the derived timer constants. The defaults of the debounce
  // block are expressed in these units, so other timers can share the 10us tick.
  localparam int CLK_HZ             = 24_000_000;
  localparam int TICK_10US_CLKS     = CLK_HZ / 100_000;   // 240
  localparam int DEBOUNCE_5MS_TICKS = 500;
  localparam int TICKS_PER_SEC      = 100_000;

  // Counter width for a counter that must hold values 0..n-1; never below one bit
  // so degenerate parameter choices still give a legal vector.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One input channel: polarity, 2-flop synchronizer, debounce counter,
// long-press counter and registered rise/fall/long-press pulses.
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_5MS_TICKS,
  parameter int LONG_TICKS     = TICKS_PER_SEC,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  input  logic i_tick,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_long_press
);

  localparam logic POL = 1'(ACTIVE_LOW);

  localparam int            DW      = cnt_w(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);

  localparam int            LW        = cnt_w(LONG_TICKS + 1);
  localparam logic [LW-1:0] LONG_FULL = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);

  logic          w_active;
  logic          w_differ;
  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          r_long;
  logic [DW-1:0] r_db_cnt;
  logic [LW-1:0] r_long_cnt;

  // Polarity is folded in ahead of the synchronizer so everything downstream is 1 = active.
  assign w_active = i_pin ^ POL;
  assign w_differ = (r_sync != r_level);

  // Two-flop synchronizer; only the second stage is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= w_active;
      r_sync <= r_meta;
    end
  end

  // Debounce: level follows sync only after DEBOUNCE_TICKS consecutive ticks of
  // disagreement; any agreement (tick or not) restarts the count. Edge pulses are
  // registered on the same edge that flips level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_differ) begin
        r_db_cnt <= '0;
      end else if (i_tick) begin
        if (r_db_cnt == DB_LAST) begin
          r_level  <= r_sync;
          r_db_cnt <= '0;
          r_rise   <= r_sync;
          r_fall   <= ~r_sync;
        end else begin
          r_db_cnt <= r_db_cnt + DB_ONE;
        end
      end
    end
  end

  // Long press: count ticks while level is held, saturate at LONG_TICKS so the
  // pulse fires once per press; dropping level rearms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_long_cnt <= '0;
      r_long     <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_level) begin
        r_long_cnt <= '0;
      end else if (i_tick && (r_long_cnt < LONG_FULL)) begin
        r_long_cnt <= r_long_cnt + LONG_ONE;
        r_long     <= (r_long_cnt == LONG_LAST);
      end
    end
  end

  assign o_level      = r_level;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_long_press = r_long;

endmodule

// File: rtl/input_debounce.sv
// Debounces N_INPUTS raw board pins into clean levels plus rise/fall/long-press
// pulses. Holds the single shared tick prescaler, which is also exported.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int N_INPUTS       = 2,
  parameter int TICK_CLKS      = TICK_10US_CLKS,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_5MS_TICKS,
  parameter int LONG_TICKS     = TICKS_PER_SEC,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] i_btn_in,
  output logic [N_INPUTS-1:0] o_level,
  output logic [N_INPUTS-1:0] o_rise,
  output logic [N_INPUTS-1:0] o_fall,
  output logic [N_INPUTS-1:0] o_long_press,
  output logic                o_tick
);

  // Parameter sanity: refuse to elaborate a configuration that cannot work.
  if (TICK_CLKS < 2) begin : g_bad_tick
    $fatal(1, "input_debounce: TICK_CLKS must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_db
    $fatal(1, "input_debounce: DEBOUNCE_TICKS must be >= 1");
  end
  if (LONG_TICKS <= DEBOUNCE_TICKS) begin : g_bad_long
    $fatal(1, "input_debounce: LONG_TICKS must exceed DEBOUNCE_TICKS");
  end
  if ((ACTIVE_LOW != 0) && (ACTIVE_LOW != 1)) begin : g_bad_pol
    $fatal(1, "input_debounce: ACTIVE_LOW must be 0 or 1");
  end

  localparam int            PW      = cnt_w(TICK_CLKS);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CLKS - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [PW-1:0] r_pre;
  logic          w_tick;

  // Tick is decoded from the terminal count, so it is 0 while the prescaler is held in reset.
  assign w_tick = (r_pre == PRE_MAX);

  // Free-running prescaler 0..TICK_CLKS-1 shared by every channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_ONE;
    end
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_pin        (i_btn_in[g]),
      .i_tick       (w_tick),
      .o_level      (o_level[g]),
      .o_rise       (o_rise[g]),
      .o_fall       (o_fall[g]),
      .o_long_press (o_long_press[g])
    );
  end

  assign o_tick = w_tick;

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce. Two instances run side by side: one
// active-high, one active-low fed with the inverted pins, so every expected
// event applies to both. Expected pulses are queued with a cycle window when
// the stimulus is driven and matched against a monitor log afterwards.
module tb_input_debounce;

  localparam int TK       = 4;
  localparam int DB       = 3;
  localparam int LG       = 10;
  localparam int LAT_LO   = 2 + TK * (DB - 1) + 1;  // 11
  localparam int LAT_HI   = 2 + TK * DB;            // 14
  localparam int LONG_DLY = TK * LG;                // 40
  localparam int K_RISE   = 0;
  localparam int K_FALL   = 1;
  localparam int K_LONG   = 2;

  typedef struct {
    int dut;
    int kind;
    int ch;
    int lo;
    int hi;
  } exp_t;

  typedef struct {
    int dut;
    int kind;
    int ch;
    int cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [1:0] btn_lo;
  logic [1:0] lv [2];
  logic [1:0] rs [2];
  logic [1:0] fl [2];
  logic [1:0] lp [2];
  logic       tk [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int   last_at [2][3][2];

  assign btn_lo = ~btn;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_debounce #(
    .N_INPUTS(2), .TICK_CLKS(TK), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LG), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .reset(reset), .i_btn_in(btn),
    .o_level(lv[0]), .o_rise(rs[0]), .o_fall(fl[0]), .o_long_press(lp[0]), .o_tick(tk[0])
  );

  input_debounce #(
    .N_INPUTS(2), .TICK_CLKS(TK), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LG), .ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .reset(reset), .i_btn_in(btn_lo),
    .o_level(lv[1]), .o_rise(rs[1]), .o_fall(fl[1]), .o_long_press(lp[1]), .o_tick(tk[1])
  );

  // Pulse monitor: log every pulse with the cycle it was seen in.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rs[d][c]) obs_q.push_back('{d, K_RISE, c, cyc});
        if (fl[d][c]) obs_q.push_back('{d, K_FALL, c, cyc});
        if (lp[d][c]) obs_q.push_back('{d, K_LONG, c, cyc});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int ch, input int lo, input int hi);
    for (int d = 0; d < 2; d++) exp_q.push_back('{d, kind, ch, lo, hi});
  endtask

  task automatic chk_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_level"}, 32'(lv[d]), 32'h0);
      chk({tag, "_rise"},  32'(rs[d]), 32'h0);
      chk({tag, "_fall"},  32'(fl[d]), 32'h0);
      chk({tag, "_long"},  32'(lp[d]), 32'h0);
      chk({tag, "_tick"},  32'(tk[d]), 32'h0);
    end
  endtask

  task automatic chk_level(input string tag, input logic [1:0] exp);
    for (int d = 0; d < 2; d++) chk(tag, 32'(lv[d]), 32'(exp));
  endtask

  // Match each queued expectation to one logged pulse inside its window, then
  // require that no unexplained pulses remain.
  task automatic check_events(input string tag);
    exp_t e;
    int   idx;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = -1;
      foreach (obs_q[k]) begin
        if (idx < 0 && obs_q[k].dut == e.dut && obs_q[k].kind == e.kind &&
            obs_q[k].ch == e.ch && obs_q[k].cyc >= e.lo && obs_q[k].cyc <= e.hi)
          idx = k;
      end
      n_cmp++;
      assert (idx >= 0) else begin
        n_err++;
        $error("FAIL %s: dut%0d kind%0d ch%0d observed no pulse, expected one in cycles %0d..%0d",
               tag, e.dut, e.kind, e.ch, e.lo, e.hi);
      end
      if (idx >= 0) begin
        last_at[e.dut][e.kind][e.ch] = obs_q[idx].cyc;
        obs_q.delete(idx);
      end
    end
    n_cmp++;
    assert (obs_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d extra pulse(s), first dut%0d kind%0d ch%0d at cycle %0d, expected none",
             tag, obs_q.size(), obs_q[0].dut, obs_q[0].kind, obs_q[0].ch, obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  initial begin
    int t;
    int f;
    int tgt;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 2; c++) last_at[d][k][c] = -1;

    // 1: pins active through reset; everything held at 0, then a clean press after release.
    btn = 2'b11;
    step(3);
    chk_quiet("rst");
    reset = 1'b0;
    t = cyc;
    expect_ev(K_RISE, 0, t + LAT_LO, t + LAT_HI);
    expect_ev(K_RISE, 1, t + LAT_LO, t + LAT_HI);
    for (int i = 0; i < 16; i++) begin
      step(1);
      for (int d = 0; d < 2; d++)
        chk("tick", 32'(tk[d]), 32'(((cyc - t) % TK) == (TK - 1)));
    end
    check_events("rst_rise");
    chk_level("rst_level", 2'b11);
    btn = 2'b00;
    t = cyc;
    expect_ev(K_FALL, 0, t + LAT_LO, t + LAT_HI);
    expect_ev(K_FALL, 1, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("rst_fall");
    chk_level("rst_low", 2'b00);

    // 2: 8-clk glitch is shorter than three ticks of disagreement.
    btn = 2'b01;
    step(8);
    btn = 2'b00;
    step(30);
    check_events("glitch");
    chk_level("glitch_level", 2'b00);

    // 3: clean press and release on ch0, too short for a long press.
    btn = 2'b01;
    t = cyc;
    expect_ev(K_RISE, 0, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("press");
    chk_level("press_level", 2'b01);
    btn = 2'b00;
    t = cyc;
    expect_ev(K_FALL, 0, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("release");
    chk_level("release_level", 2'b00);

    // 4: long press on ch1, twice, one pulse each, LONG_TICKS ticks after the rise.
    for (int r = 0; r < 2; r++) begin
      btn = 2'b10;
      t = cyc;
      expect_ev(K_RISE, 1, t + LAT_LO, t + LAT_HI);
      expect_ev(K_LONG, 1, t + LAT_LO + LONG_DLY, t + LAT_HI + LONG_DLY);
      step(80);
      btn = 2'b00;
      expect_ev(K_FALL, 1, t + 80 + LAT_LO, t + 80 + LAT_HI);
      step(20);
      check_events("long");
      for (int d = 0; d < 2; d++)
        chk("long_delay", 32'(last_at[d][K_LONG][1] - last_at[d][K_RISE][1]), 32'(LONG_DLY));
      chk_level("long_level", 2'b00);
    end

    // 5: both channels pressed together, then ch0 released while ch1 long-presses.
    btn = 2'b11;
    t = cyc;
    expect_ev(K_RISE, 0, t + LAT_LO, t + LAT_HI);
    expect_ev(K_RISE, 1, t + LAT_LO, t + LAT_HI);
    expect_ev(K_LONG, 1, t + LAT_LO + LONG_DLY, t + LAT_HI + LONG_DLY);
    step(30);
    btn = 2'b10;
    expect_ev(K_FALL, 0, t + 30 + LAT_LO, t + 30 + LAT_HI);
    step(30);
    check_events("indep");
    for (int d = 0; d < 2; d++)
      chk("indep_same_clk", 32'(last_at[d][K_RISE][0]), 32'(last_at[d][K_RISE][1]));
    chk_level("indep_level", 2'b10);
    btn = 2'b00;
    t = cyc;
    expect_ev(K_FALL, 1, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("indep_rel");
    chk_level("indep_low", 2'b00);

    // 6: reset in the middle of a press (long counter at 5) clears at once, no fall.
    btn = 2'b01;
    t = cyc;
    expect_ev(K_RISE, 0, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("mid_press");
    f   = last_at[0][K_RISE][0];
    tgt = (f > 0) ? f + 5 * TK + 1 : cyc + 1;
    while (cyc < tgt) step(1);
    chk_level("mid_level", 2'b01);
    reset = 1'b1;
    #1;
    chk_quiet("mid_rst");
    step(3);
    reset = 1'b0;
    t = cyc;
    expect_ev(K_RISE, 0, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("mid_rearm");
    chk_level("mid_rearm_level", 2'b01);
    btn = 2'b00;
    t = cyc;
    expect_ev(K_FALL, 0, t + LAT_LO, t + LAT_HI);
    step(20);
    check_events("mid_release");
    chk_level("mid_release_level", 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
